// File: rtl/game_pkg.sv
// Shared definitions for the game controller: state encoding, screen geometry
// and default gameplay tuning values.
package game_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWGUN  = 2'd2,
    OVER    = 2'd3
  } game_state_t;

  localparam int MAX_X = 640;
  localparam int MAX_Y = 480;

  localparam int LIFE_INIT_DEF      = 3;
  localparam int LEVEL_MAX_DEF      = 7;
  localparam int HITS_PER_LEVEL_DEF = 10;
  localparam int RESPAWN_FRAMES_DEF = 60;

endpackage

// File: rtl/bcd_cnt2.sv
// Two-digit BCD score counter; counts 00..99 and wraps back to 00.
module bcd_cnt2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  logic [3:0] dig1_q, dig1_d;
  logic [3:0] dig0_q, dig0_d;

  always_comb begin
    dig1_d = dig1_q;
    dig0_d = dig0_q;
    if (clr) begin
      dig1_d = 4'd0;
      dig0_d = 4'd0;
    end else if (inc) begin
      if (dig0_q == 4'd9) begin
        dig0_d = 4'd0;
        dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
      end else begin
        dig0_d = dig0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig1_q <= 4'd0;
      dig0_q <= 4'd0;
    end else begin
      dig1_q <= dig1_d;
      dig0_q <= dig0_d;
    end
  end

  assign dig1 = dig1_q;
  assign dig0 = dig0_q;

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: new game, play, respawn and game-over sequencing with
// lives, level progression and BCD score. Pulse inputs are single-cycle events.
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIFE_INIT      = LIFE_INIT_DEF,
  parameter int LEVEL_MAX      = LEVEL_MAX_DEF,
  parameter int HITS_PER_LEVEL = HITS_PER_LEVEL_DEF,
  parameter int RESPAWN_FRAMES = RESPAWN_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refr_tick,
  input  logic       start_key,
  input  logic       hit,
  input  logic       miss,
  output logic       game_stop,
  output logic       game_over,
  output logic [1:0] state,
  output logic [1:0] life,
  output logic [2:0] level,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [3:0] obs_speed
);

  localparam logic [1:0] LIFE_V  = 2'(LIFE_INIT);
  localparam logic [2:0] LVMAX_V = 3'(LEVEL_MAX);
  localparam logic [3:0] HITS_V  = 4'(HITS_PER_LEVEL);
  localparam logic [5:0] RESP_V  = 6'(RESPAWN_FRAMES);

  game_state_t state_q, state_d;
  logic [1:0]  life_q, life_d;
  logic [2:0]  level_q, level_d;
  logic [3:0]  hits_q, hits_d;
  logic [5:0]  frame_q, frame_d;
  logic        start_key_q;
  logic        start_edge;
  logic        score_clr;
  logic        score_inc;

  assign start_edge = start_key & ~start_key_q;

  always_comb begin
    state_d   = state_q;
    life_d    = life_q;
    level_d   = level_q;
    hits_d    = hits_q;
    frame_d   = frame_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    case (state_q)
      NEWGAME: begin
        if (start_edge) state_d = PLAY;
      end
      PLAY: begin
        if (hit) begin
          score_inc = 1'b1;
          // At the top level the hit counter sticks at its threshold.
          if ((hits_q + 4'd1 == HITS_V) && (level_q < LVMAX_V)) begin
            level_d = level_q + 3'd1;
            hits_d  = 4'd0;
          end else if (hits_q < HITS_V) begin
            hits_d = hits_q + 4'd1;
          end
        end
        if (miss) begin
          if (life_q == 2'd1) begin
            life_d  = 2'd0;
            state_d = OVER;
          end else begin
            life_d  = life_q - 2'd1;
            frame_d = 6'd0;
            state_d = NEWGUN;
          end
        end
      end
      NEWGUN: begin
        if (start_edge) begin
          state_d = PLAY;
        end else if (refr_tick) begin
          frame_d = frame_q + 6'd1;
          if (frame_d == RESP_V) state_d = PLAY;
        end
      end
      OVER: begin
        // Fresh game values are loaded on the way out so NEWGAME shows them.
        if (start_edge) begin
          state_d   = NEWGAME;
          score_clr = 1'b1;
          life_d    = LIFE_V;
          level_d   = 3'd1;
          hits_d    = 4'd0;
          frame_d   = 6'd0;
        end
      end
      default: state_d = NEWGAME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= NEWGAME;
      life_q      <= LIFE_V;
      level_q     <= 3'd1;
      hits_q      <= 4'd0;
      frame_q     <= 6'd0;
      start_key_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      life_q      <= life_d;
      level_q     <= level_d;
      hits_q      <= hits_d;
      frame_q     <= frame_d;
      start_key_q <= start_key;
    end
  end

  bcd_cnt2 u_score (
    .clk  (clk),
    .rst  (rst),
    .clr  (score_clr),
    .inc  (score_inc),
    .dig1 (dig1),
    .dig0 (dig0)
  );

  assign state     = state_q;
  assign game_stop = (state_q != PLAY);
  assign game_over = (state_q == OVER);
  assign life      = life_q;
  assign level     = level_q;
  assign obs_speed = {1'b0, level_q} + 4'd2;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: reset, start, scoring/levels, respawn,
// simultaneous hit+miss, held-key suppression and reset during respawn.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       refr_tick;
  logic       start_key;
  logic       hit;
  logic       miss;
  logic       game_stop;
  logic       game_over;
  logic [1:0] state;
  logic [1:0] life;
  logic [2:0] level;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic [3:0] obs_speed;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .refr_tick (refr_tick),
    .start_key (start_key),
    .hit       (hit),
    .miss      (miss),
    .game_stop (game_stop),
    .game_over (game_over),
    .state     (state),
    .life      (life),
    .level     (level),
    .dig1      (dig1),
    .dig0      (dig0),
    .obs_speed (obs_speed)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_refr(input int n);
    repeat (n) begin
      refr_tick = 1'b1;
      tick(1);
      refr_tick = 1'b0;
      tick(1);
    end
  endtask

  task automatic pulse_miss();
    miss = 1'b1;
    tick(1);
    miss = 1'b0;
  endtask

  task automatic test_reset();
    start_key = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
    checks++; if (game_stop !== 1'b1) begin errors++; $display("FAIL rst_game_stop: got %0b want 1", game_stop); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL rst_game_over: got %0b want 0", game_over); end
    checks++; if (life !== 2'd3) begin errors++; $display("FAIL rst_life: got %0d want 3", life); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL rst_level: got %0d want 1", level); end
    checks++; if ({dig1, dig0} !== 8'h00) begin errors++; $display("FAIL rst_score: got %0d%0d want 00", dig1, dig0); end
    checks++; if (obs_speed !== 4'd3) begin errors++; $display("FAIL rst_obs_speed: got %0d want 3", obs_speed); end
    tick(3);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_held_key: got state %0d want 0", state); end
    start_key = 1'b0;
    tick(1);
  endtask

  task automatic test_start();
    start_key = 1'b1;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_no_comb: got %0d want 0", state); end
    tick(1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d want 1", state); end
    checks++; if (game_stop !== 1'b0) begin errors++; $display("FAIL start_game_stop: got %0b want 0", game_stop); end
    start_key = 1'b0;
    tick(1);
  endtask

  task automatic test_hits();
    int total;
    logic [2:0] exp_level;
    logic [7:0] exp_score;
    for (int i = 1; i <= 100; i++) exp_q.push_back(8'(((i % 100) / 10) * 16 + (i % 10)));
    total = 0;
    hit = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      total++;
      exp_level = (total / 10 >= 6) ? 3'd7 : 3'(1 + total / 10);
      exp_score = exp_q.pop_front();
      checks++; if ({dig1, dig0} !== exp_score) begin errors++; $display("FAIL hit_score[%0d]: got %h want %h", i, {dig1, dig0}, exp_score); end
      checks++; if (level !== exp_level) begin errors++; $display("FAIL hit_level[%0d]: got %0d want %0d", i, level, exp_level); end
      if (i == 12) begin
        checks++; if (obs_speed !== 4'd4) begin errors++; $display("FAIL hit_obs_speed12: got %0d want 4", obs_speed); end
      end
    end
    hit = 1'b0;
    tick(1);
    checks++; if ({dig1, dig0} !== 8'h00) begin errors++; $display("FAIL hit_wrap: got %h want 00", {dig1, dig0}); end
    checks++; if (obs_speed !== 4'd9) begin errors++; $display("FAIL hit_obs_speed_max: got %0d want 9", obs_speed); end
  endtask

  task automatic test_respawn();
    pulse_miss();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL miss1_state: got %0d want 2", state); end
    checks++; if (life !== 2'd2) begin errors++; $display("FAIL miss1_life: got %0d want 2", life); end
    checks++; if (game_stop !== 1'b1) begin errors++; $display("FAIL miss1_game_stop: got %0b want 1", game_stop); end
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    checks++; if ({dig1, dig0} !== 8'h00) begin errors++; $display("FAIL newgun_hit_ignored: got %h want 00", {dig1, dig0}); end
    pulse_refr(59);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL respawn59: got %0d want 2", state); end
    pulse_refr(1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL respawn60: got %0d want 1", state); end
    checks++; if (level !== 3'd7 || life !== 2'd2) begin errors++; $display("FAIL respawn_held: got level %0d life %0d want 7 2", level, life); end
    pulse_miss();
    checks++; if (state !== 2'd2 || life !== 2'd1) begin errors++; $display("FAIL miss2: got state %0d life %0d want 2 1", state, life); end
    pulse_refr(20);
    start_key = 1'b1;
    tick(1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL respawn_key: got %0d want 1", state); end
  endtask

  task automatic test_hit_miss_same();
    hit = 1'b1;
    miss = 1'b1;
    tick(1);
    hit = 1'b0;
    miss = 1'b0;
    checks++; if ({dig1, dig0} !== 8'h01) begin errors++; $display("FAIL hm_score: got %h want 01", {dig1, dig0}); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL hm_state: got %0d want 3", state); end
    checks++; if (life !== 2'd0) begin errors++; $display("FAIL hm_life: got %0d want 0", life); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL hm_game_over: got %0b want 1", game_over); end
    hit = 1'b1;
    tick(5);
    hit = 1'b0;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL over_held_key: got %0d want 3", state); end
    checks++; if ({dig1, dig0} !== 8'h01) begin errors++; $display("FAIL over_hit_ignored: got %h want 01", {dig1, dig0}); end
    start_key = 1'b0;
    tick(1);
    start_key = 1'b1;
    tick(1);
    start_key = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL over_restart: got %0d want 0", state); end
    checks++; if (life !== 2'd3 || level !== 3'd1 || {dig1, dig0} !== 8'h00 || game_over !== 1'b0) begin
      errors++; $display("FAIL newgame_values: got life %0d level %0d score %h over %0b want 3 1 00 0", life, level, {dig1, dig0}, game_over);
    end
    tick(1);
  endtask

  task automatic test_reset_newgun();
    start_key = 1'b1;
    tick(1);
    start_key = 1'b0;
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    pulse_miss();
    pulse_refr(30);
    checks++; if (state !== 2'd2 || {dig1, dig0} !== 8'h01) begin errors++; $display("FAIL pre_rst: got state %0d score %h want 2 01", state, {dig1, dig0}); end
    start_key = 1'b1;
    refr_tick = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    refr_tick = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d want 0", state); end
    checks++; if (life !== 2'd3 || level !== 3'd1 || {dig1, dig0} !== 8'h00 || game_stop !== 1'b1) begin
      errors++; $display("FAIL midrst_values: got life %0d level %0d score %h stop %0b want 3 1 00 1", life, level, {dig1, dig0}, game_stop);
    end
    tick(3);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL midrst_held_key: got %0d want 0", state); end
    start_key = 1'b0;
    tick(1);
    start_key = 1'b1;
    tick(1);
    start_key = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL midrst_repress: got %0d want 1", state); end
    pulse_miss();
    pulse_refr(59);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL frame_clear59: got %0d want 2", state); end
    pulse_refr(1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL frame_clear60: got %0d want 1", state); end
  endtask

  initial begin
    rst = 1'b0;
    refr_tick = 1'b0;
    start_key = 1'b0;
    hit = 1'b0;
    miss = 1'b0;
    test_reset();
    test_start();
    test_hits();
    test_respawn();
    test_hit_miss_same();
    test_reset_newgun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter LIFE_INIT, default 3, lives loaded at new game (2-bit, range 1..3).
REQ-002 Parameter LEVEL_MAX, default 7, highest level reachable (3-bit).
REQ-003 Parameter HITS_PER_LEVEL, default 10, hits within one level that trigger a level-up (range 1..15).
REQ-004 Parameter RESPAWN_FRAMES, default 60, frames spent in NEWGUN before PLAY resumes automatically (range 1..63).
REQ-005 Port clk, input, 1 bit: single clock; clock domain of all logic.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port refr_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-008 Port start_key, input, 1 bit: raw level of the start/fire key (key[4]).
REQ-009 Port hit, input, 1 bit: one-cycle pulse, shot struck obstacle.
REQ-010 Port miss, input, 1 bit: one-cycle pulse, shot/obstacle missed.
REQ-011 Port game_stop, output, 1 bit: freezes and re-centres the datapath objects.
REQ-012 Port game_over, output, 1 bit: enables the "Game Over" text.
REQ-013 Port state, output, 2 bits: current FSM state.
REQ-014 Port life, output, 2 bits: remaining lives.
REQ-015 Port level, output, 3 bits: current level.
REQ-016 Port dig1 and dig0, output, 4 bits each: BCD score, tens and units.
REQ-017 Port obs_speed, output, 4 bits: obstacle vertical velocity, equal to level+2.

Function
REQ-018 The FSM SHALL have four states: NEWGAME=0, PLAY=1, NEWGUN=2, OVER=3.
REQ-019 start_key SHALL be registered once. start_edge = start_key AND NOT start_key_q. Only start_edge advances the FSM; a held key never re-triggers.
REQ-020 NEWGAME behaviour:
- score cleared, life=LIFE_INIT, level=1, level-hit counter=0.
- start_edge -> PLAY on the next clock edge.
REQ-021 Hit handling in PLAY (hit=1):
- score increments in BCD: units 9->0 with tens+1; 99 wraps to 00.
- level-hit counter +1.
REQ-022 Level-up in PLAY: when the level-hit counter reaches HITS_PER_LEVEL and level<LEVEL_MAX, level+1 and the counter clears in the same edge. At LEVEL_MAX the counter saturates and level holds.
REQ-023 Miss handling in PLAY (miss=1):
- if life==1: life=0 and -> OVER.
- otherwise: life-1 and -> NEWGUN.
REQ-024 hit and miss asserted in the same cycle: the hit is scored first, then the miss is processed, both on one edge.
REQ-025 hit and miss SHALL be ignored in every state other than PLAY.
REQ-026 NEWGUN behaviour:
- a 6-bit frame counter clears on entry and increments on each refr_tick.
- -> PLAY when the counter reaches RESPAWN_FRAMES or on start_edge, whichever comes first.
- score, life and level are held.
REQ-027 OVER behaviour: game_over=1 and all counters held; start_edge -> NEWGAME.
REQ-028 All outputs SHALL be registered or decoded from registers only, with no combinational path from any input to any output.
REQ-029 Output decode from state:
- game_stop=0 only in PLAY.
- game_over=1 only in OVER.
- state changes one clock after the cycle in which the triggering event is sampled.
REQ-030 Unreachable state encodings SHALL not exist. With 2-bit encoding all four codes are legal, so a default branch returning to NEWGAME is still required.

Reset
REQ-031 While rst=1 at a clock edge, the following SHALL load, overriding any concurrent event:
- state=NEWGAME, game_stop=1, game_over=0.
- life=LIFE_INIT, level=1, dig1=dig0=0, obs_speed=3.
- all counters=0, start_key_q=1, which suppresses a false edge while the key is held through reset.
REQ-032 Reset asserted mid-PLAY or mid-NEWGUN SHALL take effect on that edge, with no partial updates.

Structure
REQ-033 Shared package game_pkg SHALL hold:
- the state encoding.
- screen constants MAX_X=640 and MAX_Y=480.
- default LIFE_INIT, LEVEL_MAX and HITS_PER_LEVEL.
REQ-034 The two-digit BCD score counter SHALL be a sub-module bcd_cnt2 with ports clk, rst, clr, inc, dig1, dig0. Everything else is inline.

Verification
REQ-035 Reset then start pulse -> state 0->1 one clock after the edge is sampled; game_stop falls; life=3, level=1, score=00.
REQ-036 In PLAY, apply 12 hit pulses -> score=12, level=2, level-hit counter=2, obs_speed=4; 99 hits then 1 more -> score=00.
REQ-037 life=3, miss -> NEWGUN, life=2; no key for 60 refr_ticks -> PLAY. Repeat until life=1, then miss -> OVER, life=0, game_over=1.
REQ-038 hit and miss in the same cycle with life=1 -> score+1 and OVER on the same edge. Holding start_key high through OVER -> no transition until release and re-press.
REQ-039 rst asserted during NEWGUN with frame count 30 and start_key high -> NEWGAME values on that edge; no PLAY entry until the key is released and pressed again.
